// File: rtl/cabac_ctx_init_loader_pkg.sv
// Shared constants and types for the CABAC context-init loader and its
// per-context arithmetic.
package cabac_ctx_init_loader_pkg;

  localparam int CTX_NUM = 64;
  localparam int ADDR_W  = 6;
  localparam int WORD_W  = 16;

  localparam logic [5:0] QP_MAX  = 6'd51;
  localparam logic [6:0] PRE_MIN = 7'd1;
  localparam logic [6:0] PRE_MAX = 7'd126;

  localparam int M_MSB = 15;
  localparam int M_LSB = 8;
  localparam int N_MSB = 7;
  localparam int N_LSB = 0;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CTX_NUM - 1);

  typedef struct packed {
    logic [5:0] p_state_idx;
    logic       val_mps;
  } ctx_state_t;

  // Slice QP above the legal maximum saturates rather than wrapping.
  function automatic logic [5:0] clip_qp(input logic [5:0] qp);
    if (qp > QP_MAX) begin
      return QP_MAX;
    end else begin
      return qp;
    end
  endfunction

endpackage

// File: rtl/cabac_ctx_init_calc.sv
// Combinational (m, n, qp) -> {pStateIdx, valMps} context initialisation,
// shared with the decoder-side init path.
module cabac_ctx_init_calc
  import cabac_ctx_init_loader_pkg::*;
(
  input  logic [7:0] m,
  input  logic [7:0] n,
  input  logic [5:0] qp_c,
  output logic [6:0] ctx_state
);

  logic signed [14:0] m_ext_s;
  logic signed [14:0] qp_ext_s;
  logic signed [14:0] prod_s;
  logic signed [15:0] prod_w_s;
  logic signed [15:0] n_w_s;
  logic signed [15:0] t_s;
  logic [6:0]         pre_s;
  ctx_state_t         st_s;

  // Slope times QP, floor-shifted, plus offset; 16 bits covers the extremes.
  always_comb begin
    m_ext_s  = {{7{m[7]}}, m};
    qp_ext_s = {9'd0, qp_c};
    prod_s   = m_ext_s * qp_ext_s;
    prod_w_s = {prod_s[14], prod_s};
    n_w_s    = {8'd0, n};
    t_s      = (prod_w_s >>> 3'd4) + n_w_s;
    pre_s    = PRE_MIN;
    st_s     = '0;
    if (t_s < $signed({9'd0, PRE_MIN})) begin
      pre_s = PRE_MIN;
    end else if (t_s > $signed({9'd0, PRE_MAX})) begin
      pre_s = PRE_MAX;
    end else begin
      pre_s = t_s[6:0];
    end
    if (pre_s <= 7'd63) begin
      st_s.val_mps     = 1'b0;
      st_s.p_state_idx = 6'(7'd63 - pre_s);
    end else begin
      st_s.val_mps     = 1'b1;
      st_s.p_state_idx = 6'(pre_s - 7'd64);
    end
  end

  assign ctx_state = st_s;

endmodule

// File: rtl/cabac_ctx_init_loader.sv
// Sweeps the context-init ROM once per slice and writes the derived
// initial context states into the context RAM.
module cabac_ctx_init_loader
  import cabac_ctx_init_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        qp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [WORD_W-1:0] rom_data_i,
  output logic              ctx_we_o,
  output logic [ADDR_W-1:0] ctx_addr_o,
  output logic [6:0]        ctx_data_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_r;
  logic              busy_r;
  logic              done_r;
  logic              rom_en_r;
  logic [ADDR_W-1:0] rom_addr_r;
  logic [5:0]        qp_c_r;
  logic              vld_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              ctx_we_r;
  logic [ADDR_W-1:0] ctx_addr_r;
  logic [6:0]        ctx_data_r;
  logic [6:0]        calc_s;

  cabac_ctx_init_calc u_calc (
    .m         (rom_data_i[M_MSB:M_LSB]),
    .n         (rom_data_i[N_MSB:N_LSB]),
    .qp_c      (qp_c_r),
    .ctx_state (calc_s)
  );

  // Sweep control: address generation, QP capture and busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rom_en_r   <= 1'b0;
      rom_addr_r <= '0;
      qp_c_r     <= 6'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            state_r    <= S_READ;
            busy_r     <= 1'b1;
            rom_en_r   <= 1'b1;
            rom_addr_r <= '0;
            qp_c_r     <= clip_qp(qp_i);
          end
        end
        S_READ: begin
          if (rom_addr_r == LAST_ADDR) begin
            state_r  <= S_DRAIN;
            rom_en_r <= 1'b0;
          end else begin
            rom_addr_r <= rom_addr_r + 1'b1;
          end
        end
        S_DRAIN: begin
          // The last write is on the bus once the read pipe has emptied.
          if (ctx_we_r && !vld_r) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= S_IDLE;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
          rom_en_r <= 1'b0;
        end
      endcase
    end
  end

  // ROM data is consumed only one cycle after an enabled read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r      <= 1'b0;
      rd_addr_r  <= '0;
      ctx_we_r   <= 1'b0;
      ctx_addr_r <= '0;
      ctx_data_r <= 7'd0;
    end else begin
      vld_r     <= rom_en_r;
      rd_addr_r <= rom_addr_r;
      if (vld_r) begin
        ctx_we_r   <= 1'b1;
        ctx_addr_r <= rd_addr_r;
        ctx_data_r <= calc_s;
      end else begin
        ctx_we_r <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign rom_en_o   = rom_en_r;
  assign rom_addr_o = rom_addr_r;
  assign ctx_we_o   = ctx_we_r;
  assign ctx_addr_o = ctx_addr_r;
  assign ctx_data_o = ctx_data_r;

endmodule

// File: tb/tb_cabac_ctx_init_loader.sv
// Self-checking bench for cabac_ctx_init_loader: ROM model, write monitor and
// an arithmetic reference model of the context-init formula.
module tb_cabac_ctx_init_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  qp_i;
  logic        busy_o, done_o, rom_en_o, ctx_we_o;
  logic [5:0]  rom_addr_o, ctx_addr_o;
  logic [15:0] rom_data_i;
  logic [6:0]  ctx_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom [64];
  int cyc  = 0;
  int base = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_rel[$];
  int done_rel[$];
  int x_errs = 0;

  cabac_ctx_init_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .qp_i       (qp_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rom_en_o   (rom_en_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .ctx_we_o   (ctx_we_o),
    .ctx_addr_o (ctx_addr_o),
    .ctx_data_o (ctx_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data is only meaningful after an enabled read.
  always @(posedge clk) rom_data_i <= rom_en_o ? rom[rom_addr_o] : 16'hxxxx;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ctx_we_o) begin
        wr_addr.push_back(int'(ctx_addr_o));
        wr_data.push_back(int'(ctx_data_o));
        wr_rel.push_back(cyc - base);
        if ($isunknown(ctx_data_o)) x_errs++;
      end
      if (done_o) done_rel.push_back(cyc - base);
    end
  end

  // Reference: H.264/HEVC context init as plain integer arithmetic.
  function automatic int model(input logic [15:0] w, input int qp);
    int qc, m, n, prod, q, pre;
    qc = (qp > 51) ? 51 : qp;
    m = int'(w[15:8]);
    if (m > 127) m = m - 256;
    n = int'(w[7:0]);
    prod = m * qc;
    q = prod / 16;
    if (prod < 0 && (prod % 16) != 0) q = q - 1;
    pre = q + n;
    if (pre < 1) pre = 1;
    if (pre > 126) pre = 126;
    if (pre <= 63) return (63 - pre) * 2;
    return (pre - 64) * 2 + 1;
  endfunction

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_rel.delete(); done_rel.delete();
    x_errs = 0;
  endtask

  task automatic fill_rom_random();
    for (int k = 0; k < 64; k++) rom[k] = 16'($urandom);
  endtask

  task automatic start_sweep(input int qp);
    @(negedge clk);
    start_i = 1'b1;
    qp_i = 6'(qp);
    base = cyc;
    @(negedge clk);
    start_i = 1'b0;
    qp_i = 6'($urandom);
  endtask

  task automatic wait_done(input int n_done, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (done_rel.size() >= n_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; qp_i = 6'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, rom_en_o, ctx_we_o, rom_addr_o, ctx_addr_o, ctx_data_o} !== 23'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {busy_o, done_o, rom_en_o, ctx_we_o, rom_addr_o, ctx_addr_o, ctx_data_o});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy_o, rom_en_o, ctx_we_o} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy_o, rom_en_o, ctx_we_o});
    end
  endtask

  task automatic test_basic();
    bit to;
    fill_rom_random();
    rom[0] = 16'hfb40;
    rom[2] = 16'h0040;
    clear_mon();
    start_sweep(32);
    wait_done(1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
    n_checks++;
    if (wr_data.size() != 64) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 64", wr_data.size()); end
    n_checks++;
    if (wr_rel[0] != 3 || wr_addr[0] != 0 || wr_data[0] != 18) begin
      n_fail++; $display("FAIL basic_first_write: got cyc %0d addr %0d data %0d expected 3 0 18", wr_rel[0], wr_addr[0], wr_data[0]);
    end
    n_checks++;
    if (wr_data[2] != 1) begin n_fail++; $display("FAIL basic_word2: got %0d expected 1", wr_data[2]); end
    n_checks++;
    if (done_rel[0] != 67) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 67", done_rel[0]); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b expected 0", busy_o); end
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (wr_addr[k] != k || wr_rel[k] != k + 3 || wr_data[k] != model(rom[k], 32)) begin
        n_fail++; $display("FAIL basic_write_%0d: got addr %0d cyc %0d data %0d expected %0d %0d %0d",
          k, wr_addr[k], wr_rel[k], wr_data[k], k, k + 3, model(rom[k], 32));
      end
    end
    n_checks++;
    if (x_errs != 0) begin n_fail++; $display("FAIL basic_x_data: got %0d expected 0", x_errs); end
  endtask

  task automatic test_qp_clip();
    bit to;
    int qps [2];
    qps[0] = 51;
    qps[1] = int'($urandom_range(52, 63));
    fill_rom_random();
    rom[0] = 16'h1908;
    rom[1] = 16'he268;
    for (int r = 0; r < 2; r++) begin
      clear_mon();
      start_sweep(qps[r]);
      wait_done(1, to);
      n_checks++;
      if (to || wr_data.size() != 64) begin
        n_fail++; $display("FAIL qp_sweep_%0d: got %0d writes expected 64", qps[r], wr_data.size());
      end
      n_checks++;
      if (wr_data[0] != 47 || wr_data[1] != 110) begin
        n_fail++; $display("FAIL qp_fixed_words_%0d: got %0d %0d expected 47 110", qps[r], wr_data[0], wr_data[1]);
      end
      for (int k = 0; k < 64; k++) begin
        n_checks++;
        if (wr_data[k] != model(rom[k], 51)) begin
          n_fail++; $display("FAIL qp_clip_%0d_%0d: got %0d expected %0d", qps[r], k, wr_data[k], model(rom[k], 51));
        end
      end
    end
  endtask

  task automatic test_clip_extremes();
    bit to;
    logic [15:0] words [2];
    int exp_v [2];
    words[0] = 16'h8000; exp_v[0] = 124;
    words[1] = 16'h7f7f; exp_v[1] = 125;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 64; k++) rom[k] = words[r];
      clear_mon();
      start_sweep(51);
      wait_done(1, to);
      n_checks++;
      if (to || wr_data.size() != 64) begin
        n_fail++; $display("FAIL extreme_sweep_%h: got %0d writes expected 64", words[r], wr_data.size());
      end
      for (int k = 0; k < 64; k++) begin
        n_checks++;
        if (wr_data[k] != exp_v[r]) begin
          n_fail++; $display("FAIL extreme_%h_%0d: got %0d expected %0d", words[r], k, wr_data[k], exp_v[r]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit to;
    int n1, n2, nstray;
    fill_rom_random();
    clear_mon();
    @(negedge clk);
    start_i = 1'b1; qp_i = 6'd20; base = cyc;
    for (int rel = 1; rel <= 68; rel++) begin
      @(negedge clk);
      start_i = (rel == 10 || rel == 67 || rel == 68);
      qp_i = 6'd45;
      if (rel == 67) begin
        n_checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b1) begin
          n_fail++; $display("FAIL busy_done_cycle: got busy %b done %b expected 1 1", busy_o, done_o);
        end
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    wait_done(2, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL busy_second_timeout: got %0d dones expected 2", done_rel.size()); end
    n_checks++;
    if (done_rel[0] != 67 || done_rel[1] != 135) begin
      n_fail++; $display("FAIL busy_done_cycles: got %0d %0d expected 67 135", done_rel[0], done_rel[1]);
    end
    n1 = 0; n2 = 0; nstray = 0;
    for (int i = 0; i < wr_data.size(); i++) begin
      if (wr_rel[i] <= 66) begin
        n1++;
        n_checks++;
        if (wr_addr[i] != wr_rel[i] - 3 || wr_data[i] != model(rom[wr_addr[i]], 20)) begin
          n_fail++; $display("FAIL busy_first_%0d: got addr %0d data %0d expected %0d %0d",
            i, wr_addr[i], wr_data[i], wr_rel[i] - 3, model(rom[wr_rel[i] - 3], 20));
        end
      end else if (wr_rel[i] <= 70) begin
        nstray++;
      end else begin
        n2++;
        n_checks++;
        if (wr_addr[i] != wr_rel[i] - 71 || wr_data[i] != model(rom[wr_addr[i]], 45)) begin
          n_fail++; $display("FAIL busy_second_%0d: got addr %0d data %0d expected %0d %0d",
            i, wr_addr[i], wr_data[i], wr_rel[i] - 71, model(rom[wr_addr[i]], 45));
        end
      end
    end
    n_checks++;
    if (n1 != 64 || n2 != 64 || nstray != 0) begin
      n_fail++; $display("FAIL busy_write_counts: got %0d %0d %0d expected 64 64 0", n1, n2, nstray);
    end
  endtask

  task automatic test_midsweep_reset();
    bit to;
    int qp;
    fill_rom_random();
    clear_mon();
    start_sweep(int'($urandom_range(0, 51)));
    repeat (29) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, rom_en_o, ctx_we_o, rom_addr_o, ctx_addr_o, ctx_data_o} !== 23'd0) begin
      n_fail++; $display("FAIL midsweep_reset_outputs: got %h expected 0",
        {busy_o, done_o, rom_en_o, ctx_we_o, rom_addr_o, ctx_addr_o, ctx_data_o});
    end
    n_checks++;
    if (wr_data.size() != 28) begin n_fail++; $display("FAIL midsweep_partial_writes: got %0d expected 28", wr_data.size()); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (80) @(negedge clk);
    n_checks++;
    if (wr_data.size() != 0 || done_rel.size() != 0) begin
      n_fail++; $display("FAIL post_reset_quiet: got %0d writes %0d dones expected 0 0", wr_data.size(), done_rel.size());
    end
    qp = int'($urandom_range(0, 63));
    clear_mon();
    start_sweep(qp);
    wait_done(1, to);
    n_checks++;
    if (to || wr_data.size() != 64 || done_rel[0] != 67) begin
      n_fail++; $display("FAIL fresh_sweep: got %0d writes done %0d expected 64 67", wr_data.size(), done_rel[0]);
    end
    for (int k = 0; k < 64; k++) begin
      n_checks++;
      if (wr_addr[k] != k || wr_data[k] != model(rom[k], qp)) begin
        n_fail++; $display("FAIL fresh_write_%0d: got addr %0d data %0d expected %0d %0d",
          k, wr_addr[k], wr_data[k], k, model(rom[k], qp));
      end
    end
    n_checks++;
    if (x_errs != 0) begin n_fail++; $display("FAIL fresh_x_data: got %0d expected 0", x_errs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_qp_clip();
    test_clip_extremes();
    test_busy_ignore();
    test_midsweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cabac_ctx_init_loader.md
Name: cabac_ctx_init_loader

Overview:
Reader side of the 64-entry CABAC context-init ROM: on a start pulse it sweeps all ROM addresses, converts each packed {slope m, offset n} word into an initial context state at the slice QP, and writes {pStateIdx, valMps} into the context-state memory. It sits between the slice-start control and the CABAC context RAM, and runs once per slice.

Parameters:
CTX_NUM, 64, number of contexts swept (= ROM depth)
ADDR_W, 6, ROM / context-RAM address width
WORD_W, 16, ROM word width: [15:8] = m (signed 8b), [7:0] = n (unsigned 8b)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse that launches a sweep; ignored while busy_o=1
qp_i  input  6  slice QP, sampled on the start_i cycle
busy_o  output  1  sweep in progress
done_o  output  1  one-cycle pulse after the last context write
rom_en_o  output  1  ROM read enable
rom_addr_o  output  ADDR_W  ROM read address
rom_data_i  input  WORD_W  ROM data, valid the cycle after rom_en_o=1; undefined otherwise
ctx_we_o  output  1  context RAM write enable
ctx_addr_o  output  ADDR_W  context RAM write address
ctx_data_o  output  7  {pStateIdx[5:0], valMps}

Behaviour:
- The clock and reset are as stated in Ports: one clock, clk; asynchronous active-low reset, rst_n.
- Reset values: busy_o, done_o, rom_en_o and ctx_we_o are 0. rom_addr_o, ctx_addr_o and ctx_data_o are 0. The FSM resets to IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ on start_i. At the same edge, latch qp_c = min(qp_i, 51).
  - READ: rom_en_o=1. rom_addr_o counts 0..CTX_NUM-1, one address per cycle. After the last address, go to DRAIN.
  - DRAIN: rom_en_o=0. Hold until the final write issues, then go to DONE.
  - DONE: done_o=1 for one cycle, then go to IDLE.
- busy_o=1 in READ, DRAIN and DONE.
- Pipeline timing:
  - Edge E0 samples start_i.
  - Cycles 1..64 carry ROM address k = cycle-1.
  - rom_data_i is sampled only in the cycle after a rom_en_o=1 cycle, using a 1-cycle valid shift register. It is never sampled otherwise.
  - Results are registered, so ctx_we_o=1 in cycles 3..66 with ctx_addr_o = k in order. That is exactly 64 contiguous writes.
  - done_o=1 in cycle 67. busy_o falls at the end of cycle 67.
- Arithmetic per word (m signed 8b, n unsigned 8b):
  - prod = m * qp_c, 15-bit signed.
  - t = (prod >>> 4) + n. The shift is arithmetic, i.e. floor.
  - pre = Clip3(1, 126, t). Size t to at least 16 bits so the extreme cases (m=-128 or 127, n=255, qp=51) cannot overflow.
  - If pre <= 63: valMps=0, pStateIdx = 63-pre.
  - Otherwise: valMps=1, pStateIdx = pre-64.
- Boundary conditions:
  - start_i while busy_o=1 is ignored; QP does not change mid-sweep.
  - qp_i > 51 is clipped to 51.
  - start_i in the DONE cycle is ignored; a start is accepted only in IDLE.
  - rst_n asserted mid-sweep: all outputs return to their reset values immediately. No partial write continues after reset release.
  - Back-to-back sweeps: start_i in the first IDLE cycle after DONE is accepted.

Decomposition:
- Shared package:
  - CTX_NUM, QP_MAX=51, PRE_MIN=1, PRE_MAX=126.
  - Field positions M_MSB=15, M_LSB=8, N_MSB=7, N_LSB=0.
  - Context-state typedef {pStateIdx[5:0], valMps}.
- One natural sub-module: cabac_ctx_init_calc. It is purely combinational, (m, n, qp_c) -> {pStateIdx, valMps}, and is reused by the decoder-side init.
- The top level holds the FSM, counters, valid pipe and output registers.

Test Plan:
1. Reset, then qp_i=32 with a real ROM model whose word 0 is 'hfb40 -> ctx_we_o first asserts in cycle 3, addr 0, data {9,0}. Word 2 ('h0040) -> {0,1}. Exactly 64 writes, done_o in cycle 67.
2. qp_i=51 -> ROM 'h1908 gives {23,1}; ROM 'he268 gives {55,0}. Repeating with qp_i=63 gives identical outputs (QP clip).
3. Stub ROM 'h8000 at qp 51 -> pre clips to 1 -> {62,0}. Stub ROM 'h7f7f at qp 51 -> pre clips to 126 -> {62,1}.
4. start_i pulsed at cycles 10 and 67 during a sweep, with a different qp_i -> no restart, no extra writes, results reflect the original QP. A new start in cycle 68 begins a second sweep.
5. rst_n low at cycle 30 -> all outputs 0 asynchronously. After release, no ctx_we_o until a new start_i. A fresh sweep completes with all 64 correct writes.
6. ROM model drives X whenever rom_en_o was 0 on the previous cycle -> ctx_data_o is never X while ctx_we_o=1 (assertion).
